// File: rtl/side_road_sensor_tx.sv
// Side-road SENSOR request transmitter: synchronises and debounces the loop detector,
// counts queued vehicles, requests service and drains the queue on green.
// Optional SENSOR_WAIT_TIMEOUT_EN adds a forced request after MAX_WAIT idle cycles.
module side_road_sensor_tx #(
    parameter int unsigned DEB_CYCLES   = 2,
    parameter int unsigned QUEUE_THRESH = 3
`ifdef SENSOR_WAIT_TIMEOUT_EN
    ,
    parameter int unsigned MAX_WAIT     = 60
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       veh_in,
    input  logic [2:0] side_road,
    output logic       SENSOR,
    output logic [7:0] queue,
    output logic [7:0] wait_cnt,
    output logic       light_err
);

    localparam logic [3:0] DEB_LIM = 4'(DEB_CYCLES);
    localparam logic [7:0] Q_TH    = 8'(QUEUE_THRESH);
`ifdef SENSOR_WAIT_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVED  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic       deb_q, deb_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [7:0] queue_q, queue_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       sensor_q, sensor_d;
    logic       light_err_q, light_err_d;

    logic green, light_ok, arrival, discharge, req_cond;

    always_comb begin
        green    = (side_road == 3'b001);
        light_ok = (side_road == 3'b001) || (side_road == 3'b010) || (side_road == 3'b100);
        light_err_d = light_err_q | ~light_ok;
    end

    // Debounce: the counter only advances while the synced input disagrees with the state
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q + 4'd1 >= DEB_LIM) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
        arrival = deb_d & ~deb_q;
    end

    always_comb begin
        discharge = (state_q == SERVED) && green;
        queue_d   = queue_q;
        if (arrival && !discharge) begin
            if (queue_q != 8'hFF) begin
                queue_d = queue_q + 8'd1;
            end
        end else if (discharge && !arrival) begin
            if (queue_q != 8'd0) begin
                queue_d = queue_q - 8'd1;
            end
        end
    end

    always_comb begin
`ifdef SENSOR_WAIT_TIMEOUT_EN
        req_cond = (queue_q >= Q_TH) || ((queue_q != 8'd0) && (wait_cnt_q == WAIT_LIM));
`else
        req_cond = (queue_q >= Q_TH);
`endif
    end

    always_comb begin
        state_d    = state_q;
        sensor_d   = sensor_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                sensor_d = 1'b0;
                if (queue_q == 8'd0) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                if (green && (queue_q != 8'd0)) begin
                    state_d    = SERVED;
                    sensor_d   = (queue_d != 8'd0);
                    wait_cnt_d = '0;
                end else if (req_cond) begin
                    state_d    = REQUEST;
                    sensor_d   = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            REQUEST: begin
                sensor_d   = 1'b1;
                wait_cnt_d = '0;
                if (green) begin
                    state_d  = SERVED;
                    sensor_d = (queue_d != 8'd0);
                end
            end
            SERVED: begin
                wait_cnt_d = '0;
                if (green) begin
                    sensor_d = (queue_d != 8'd0);
                end else begin
                    state_d  = IDLE;
                    sensor_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                sensor_d   = 1'b0;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            queue_q     <= '0;
            wait_cnt_q  <= '0;
            sensor_q    <= 1'b0;
            light_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= veh_in;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            queue_q     <= queue_d;
            wait_cnt_q  <= wait_cnt_d;
            sensor_q    <= sensor_d;
            light_err_q <= light_err_d;
        end
    end

    assign SENSOR    = sensor_q;
    assign queue     = queue_q;
    assign wait_cnt  = wait_cnt_q;
    assign light_err = light_err_q;

endmodule

// File: tb/tb_side_road_sensor_tx.sv
// Directed self-checking bench for side_road_sensor_tx (default parameters).
module tb_side_road_sensor_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       veh_in;
    logic [2:0] side_road;
    logic       SENSOR;
    logic [7:0] queue;
    logic [7:0] wait_cnt;
    logic       light_err;

    int n_cmp = 0;
    int n_err = 0;

    side_road_sensor_tx #(
        .DEB_CYCLES  (2),
        .QUEUE_THRESH(3)
`ifdef SENSOR_WAIT_TIMEOUT_EN
        ,
        .MAX_WAIT    (60)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .veh_in   (veh_in),
        .side_road(side_road),
        .SENSOR   (SENSOR),
        .queue    (queue),
        .wait_cnt (wait_cnt),
        .light_err(light_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        veh_in = 1'b0;
        tick(2);
        rst    = 1'b0;
    endtask

    // One clean vehicle: the queue counts it on the 4th edge after the rise
    task automatic pulse();
        veh_in = 1'b1;
        tick(3);
        veh_in = 1'b0;
        tick(3);
    endtask

    initial begin
        rst       = 1'b1;
        veh_in    = 1'b1;
        side_road = 3'b100;
        tick();
        chk("rst1_sensor", {7'd0, SENSOR}, 8'd0);
        chk("rst1_queue", queue, 8'd0);
        chk("rst1_wait", wait_cnt, 8'd0);
        chk("rst1_lerr", {7'd0, light_err}, 8'd0);
        tick();
        chk("rst2_sensor", {7'd0, SENSOR}, 8'd0);
        chk("rst2_queue", queue, 8'd0);
        chk("rst2_lerr", {7'd0, light_err}, 8'd0);
        rst    = 1'b0;
        veh_in = 1'b0;
        tick(6);
        chk("post_rst_queue", queue, 8'd0);

        // Glitch rejection, then a 3-cycle vehicle
        veh_in = 1'b1;
        tick();
        veh_in = 1'b0;
        tick(6);
        chk("glitch_queue", queue, 8'd0);
        veh_in = 1'b1;
        tick(3);
        chk("deb_early_queue", queue, 8'd0);
        veh_in = 1'b0;
        tick();
        chk("deb_queue", queue, 8'd1);
        tick(6);

        // Threshold request
        side_road = 3'b100;
        do_reset();
        pulse();
        pulse();
        veh_in = 1'b1;
        tick(3);
        veh_in = 1'b0;
        tick();
        chk("thr_queue", queue, 8'd3);
        chk("thr_sensor_pre", {7'd0, SENSOR}, 8'd0);
        chk("thr_wait", wait_cnt, 8'd12);
        tick();
        chk("thr_sensor", {7'd0, SENSOR}, 8'd1);
        chk("thr_wait_clr", wait_cnt, 8'd0);
        tick(3);

        // Service and drain
        side_road = 3'b001;
        tick();
        chk("srv_entry_queue", queue, 8'd3);
        chk("srv_entry_sensor", {7'd0, SENSOR}, 8'd1);
        tick();
        chk("drain_q2", queue, 8'd2);
        tick();
        chk("drain_q1", queue, 8'd1);
        chk("drain_q1_sensor", {7'd0, SENSOR}, 8'd1);
        tick();
        chk("drain_q0", queue, 8'd0);
        chk("drain_q0_sensor", {7'd0, SENSOR}, 8'd0);
        tick();
        chk("drain_hold_q", queue, 8'd0);
        side_road = 3'b010;
        tick();
        chk("exit_sensor", {7'd0, SENSOR}, 8'd0);
        chk("exit_queue", queue, 8'd0);
        chk("exit_wait", wait_cnt, 8'd0);
        tick(2);
        chk("idle_sensor", {7'd0, SENSOR}, 8'd0);

        // Single vehicle waiting on red
        side_road = 3'b100;
        do_reset();
        pulse();
        chk("to_wait2", wait_cnt, 8'd2);
        tick(58);
        chk("to_wait60", wait_cnt, 8'd60);
        chk("to_sensor_pre", {7'd0, SENSOR}, 8'd0);
        tick();
`ifdef SENSOR_WAIT_TIMEOUT_EN
        chk("to_sensor", {7'd0, SENSOR}, 8'd1);
        chk("to_wait_clr", wait_cnt, 8'd0);
`else
        chk("to_sensor_off", {7'd0, SENSOR}, 8'd0);
        chk("to_wait61", wait_cnt, 8'd61);
        tick(194);
        chk("to_wait_sat", wait_cnt, 8'd255);
        tick();
        chk("to_wait_hold", wait_cnt, 8'd255);
        chk("to_sensor_hold", {7'd0, SENSOR}, 8'd0);
`endif

        // Illegal light code: sticky error, not green
        side_road = 3'b011;
        tick();
        chk("lerr_set", {7'd0, light_err}, 8'd1);
`ifdef SENSOR_WAIT_TIMEOUT_EN
        chk("lerr_sensor", {7'd0, SENSOR}, 8'd1);
`else
        chk("lerr_sensor", {7'd0, SENSOR}, 8'd0);
`endif
        chk("lerr_queue", queue, 8'd1);
        side_road = 3'b100;
        tick(3);
        chk("lerr_sticky", {7'd0, light_err}, 8'd1);

        // Queue saturation
        do_reset();
        chk("lerr_rst", {7'd0, light_err}, 8'd0);
        for (int i = 0; i < 255; i++) begin
            pulse();
        end
        chk("sat_q255", queue, 8'd255);
        chk("sat_sensor", {7'd0, SENSOR}, 8'd1);
        pulse();
        chk("sat_hold", queue, 8'd255);

        // Mid-operation reset, then direct IDLE -> SERVED on green
        do_reset();
        chk("midrst_queue", queue, 8'd0);
        chk("midrst_sensor", {7'd0, SENSOR}, 8'd0);
        pulse();
        chk("dir_queue", queue, 8'd1);
        side_road = 3'b001;
        tick();
        chk("dir_sensor", {7'd0, SENSOR}, 8'd1);
        chk("dir_queue_hold", queue, 8'd1);
        tick();
        chk("dir_drain", queue, 8'd0);
        chk("dir_sensor_off", {7'd0, SENSOR}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
